// File: rtl/pc_seq_pkg.sv
// Shared definitions for the instruction sequencer: word width, state encoding
// and the default reset PC.
package pc_seq_pkg;

    localparam int XLEN = 32;
    localparam int WD_W = 8;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        HALT   = 3'd4
    } state_t;

endpackage

// File: rtl/fetch_watchdog.sv
// Counts cycles spent waiting for instruction memory; flags expiry once the
// count reaches TIMEOUT-1.
module fetch_watchdog
    import pc_seq_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [WD_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == WD_W'(TIMEOUT - 1));

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer owning the architectural PC, the
// instruction register, the retired-instruction count and halt/fault status.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC      = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] PC_STEP       = 32'd1,
    parameter int              FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_data,
    output logic [31:0] ir,
    output logic        decode_valid,
    input  logic        is_branch,
    output logic        exec_en,
    output logic        xfer_en,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        exec_done,
    input  logic        halt_req,
    output logic [31:0] pc,
    output logic [31:0] retired,
    output logic        halted,
    output logic        fault
);

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_ir;
    logic [XLEN-1:0] r_retired;
    logic            r_fault;
    logic            r_halt_pending;
    logic            r_br_flag;

    logic            w_in_fetch;
    logic            w_wd_expired;
    logic [XLEN-1:0] w_pc_next;

    assign w_in_fetch = (r_state == FETCH);
    assign w_pc_next  = (r_br_flag && branch_taken) ? branch_target : r_pc + PC_STEP;

    // Counter is held at zero outside FETCH so every fetch starts a fresh window.
    fetch_watchdog #(
        .TIMEOUT (FETCH_TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (!w_in_fetch || imem_valid),
        .i_en      (w_in_fetch && !imem_valid),
        .o_expired (w_wd_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_pc           <= RESET_PC;
            r_ir           <= '0;
            r_retired      <= '0;
            r_fault        <= 1'b0;
            r_halt_pending <= 1'b0;
            r_br_flag      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (halt_req) begin
                        r_state <= HALT;
                    end else if (start) begin
                        r_state <= FETCH;
                        r_pc    <= RESET_PC;
                    end
                end
                FETCH: begin
                    if (halt_req) r_halt_pending <= 1'b1;
                    // A response arriving on the timeout cycle still counts as a fetch.
                    if (imem_valid) begin
                        r_ir    <= imem_data;
                        r_state <= DECODE;
                    end else if (w_wd_expired) begin
                        r_fault <= 1'b1;
                        r_state <= HALT;
                    end
                end
                DECODE: begin
                    if (halt_req) r_halt_pending <= 1'b1;
                    r_br_flag <= is_branch;
                    r_state   <= EXEC;
                end
                EXEC: begin
                    if (halt_req) r_halt_pending <= 1'b1;
                    if (exec_done) begin
                        r_pc      <= w_pc_next;
                        r_retired <= r_retired + 1'b1;
                        r_state   <= (r_halt_pending || halt_req) ? HALT : FETCH;
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign imem_req     = w_in_fetch;
    assign imem_addr    = w_in_fetch ? r_pc : '0;
    assign decode_valid = (r_state == DECODE);
    assign exec_en      = (r_state == EXEC);
    assign xfer_en      = (r_state == EXEC) && r_br_flag;
    assign halted       = (r_state == HALT);
    assign pc           = r_pc;
    assign ir           = r_ir;
    assign retired      = r_retired;
    assign fault        = r_fault;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed table, multi-cycle corner sequences and a
// randomized run against an instruction-level reference model.
module tb_pc_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, imem_valid, is_branch, branch_taken, exec_done, halt_req;
    logic [31:0] imem_data, branch_target;
    logic        imem_req, decode_valid, exec_en, xfer_en, halted, fault;
    logic [31:0] imem_addr, ir, pc, retired;

    logic        w_start, w_valid, w_done;
    logic        w_req, w_dv, w_ex, w_xf, w_halted, w_fault;
    logic [31:0] w_addr, w_ir, w_pc, w_ret;

    pc_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
        .ir(ir), .decode_valid(decode_valid), .is_branch(is_branch),
        .exec_en(exec_en), .xfer_en(xfer_en), .branch_taken(branch_taken),
        .branch_target(branch_target), .exec_done(exec_done), .halt_req(halt_req),
        .pc(pc), .retired(retired), .halted(halted), .fault(fault)
    );

    pc_sequencer #(.RESET_PC(32'hFFFF_FFFF)) dut_wrap (
        .clk(clk), .rst(rst), .start(w_start),
        .imem_req(w_req), .imem_addr(w_addr), .imem_valid(w_valid), .imem_data(32'h1234_5678),
        .ir(w_ir), .decode_valid(w_dv), .is_branch(1'b0),
        .exec_en(w_ex), .xfer_en(w_xf), .branch_taken(1'b0),
        .branch_target(32'h0), .exec_done(w_done), .halt_req(1'b0),
        .pc(w_pc), .retired(w_ret), .halted(w_halted), .fault(w_fault)
    );

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;
    int last_dec;
    int prev_ewait;
    bit have_prev;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        rst_before;
        logic        br;
        logic        tk;
        logic [31:0] tgt;
        int          fwait;
        int          ewait;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[15];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic do_reset;
        rst = 1'b1; start = 1'b0; imem_valid = 1'b0; imem_data = '0; is_branch = 1'b0;
        branch_taken = 1'b0; branch_target = '0; exec_done = 1'b0; halt_req = 1'b0;
        w_start = 1'b0; w_valid = 1'b0; w_done = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        have_prev = 1'b0;
        tick;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    // Drives one whole instruction starting from the first FETCH cycle.
    task automatic do_instr(input logic br, input logic tk, input logic [31:0] tgt,
                            input int fwait, input int ewait, input logic hd,
                            input logic [31:0] exp_fetch, input logic [31:0] exp_pc,
                            input logic [31:0] exp_ret, input logic exp_halt);
        logic [31:0] word;
        word = $urandom;
        chk("fetch_req", 32'(imem_req), 32'd1);
        chk("fetch_addr", imem_addr, exp_fetch);
        chk("fetch_xfer", 32'(xfer_en), 32'd0);
        for (int i = 0; i < fwait; i++) begin
            exec_done = 1'($urandom_range(0, 1));
            tick;
        end
        exec_done  = 1'b0;
        imem_valid = 1'b1;
        imem_data  = word;
        tick;
        imem_valid = 1'b0;
        chk("decode_valid", 32'(decode_valid), 32'd1);
        chk("ir", ir, word);
        chk("decode_exec_en", 32'(exec_en), 32'd0);
        if (have_prev) chk("decode_spacing", 32'(cyc - last_dec), 32'(prev_ewait + fwait + 3));
        last_dec   = cyc;
        prev_ewait = ewait;
        have_prev  = 1'b1;
        is_branch  = br;
        halt_req   = hd;
        tick;
        is_branch  = 1'b0;
        halt_req   = 1'b0;
        chk("exec_en", 32'(exec_en), 32'd1);
        chk("xfer_en", 32'(xfer_en), 32'(br));
        chk("exec_decode_valid", 32'(decode_valid), 32'd0);
        for (int i = 0; i < ewait; i++) begin
            imem_valid = 1'($urandom_range(0, 1));
            tick;
        end
        imem_valid    = 1'b0;
        exec_done     = 1'b1;
        branch_taken  = tk;
        branch_target = tgt;
        tick;
        exec_done     = 1'b0;
        branch_taken  = 1'b0;
        chk("pc", pc, exp_pc);
        chk("retired", retired, exp_ret);
        chk("halted", 32'(halted), 32'(exp_halt));
        chk("fault", 32'(fault), 32'd0);
    endtask

    initial begin
        logic [31:0] cur, nxt;
        int          ret;
        logic        br, tk;
        logic [31:0] tgt;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,         0,  0, 32'd1};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,         0,  0, 32'd2};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,         0,  0, 32'd3};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,         0,  0, 32'd4};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,         0,  0, 32'd1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,         0,  0, 32'd2};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 32'h40,        0,  0, 32'h40};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,         0,  0, 32'h41};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,         0,  0, 32'd1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,         0,  0, 32'd2};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h40,        0,  0, 32'd3};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 32'h77,        0,  2, 32'd4};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h0,         15, 0, 32'd5};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 2,  1, 32'hFFFF_FFFF};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h0,         0,  0, 32'd0};

        do_reset;
        chk("rst_pc", pc, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_dv", 32'(decode_valid), 32'd0);
        chk("rst_exec", 32'(exec_en), 32'd0);
        chk("rst_xfer", 32'(xfer_en), 32'd0);
        chk("rst_wrap_pc", w_pc, 32'hFFFF_FFFF);

        // PC wrap-around from an all-ones reset vector.
        w_start = 1'b1;
        tick;
        w_start = 1'b0;
        chk("wrap_addr", w_addr, 32'hFFFF_FFFF);
        w_valid = 1'b1;
        tick;
        w_valid = 1'b0;
        chk("wrap_dv", 32'(w_dv), 32'd1);
        tick;
        chk("wrap_exec", 32'(w_ex), 32'd1);
        w_done = 1'b1;
        tick;
        w_done = 1'b0;
        chk("wrap_pc", w_pc, 32'd0);
        chk("wrap_retired", w_ret, 32'd1);

        cur = '0;
        ret = 0;
        for (int i = 0; i < 15; i++) begin
            if (tbl[i].rst_before) begin
                do_reset;
                do_start;
                cur = '0;
                ret = 0;
            end
            ret++;
            do_instr(tbl[i].br, tbl[i].tk, tbl[i].tgt, tbl[i].fwait, tbl[i].ewait, 1'b0,
                     cur, tbl[i].exp_pc, 32'(ret), 1'b0);
            cur = tbl[i].exp_pc;
        end

        // Fetch timeout: memory never answers.
        do_reset;
        do_start;
        repeat (15) tick;
        chk("to_halted_early", 32'(halted), 32'd0);
        chk("to_req_16th", 32'(imem_req), 32'd1);
        chk("to_fault_early", 32'(fault), 32'd0);
        tick;
        chk("to_fault", 32'(fault), 32'd1);
        chk("to_halted", 32'(halted), 32'd1);
        chk("to_req_off", 32'(imem_req), 32'd0);
        start = 1'b1;
        imem_valid = 1'b1;
        tick;
        start = 1'b0;
        imem_valid = 1'b0;
        chk("to_stays_halted", 32'(halted), 32'd1);
        chk("to_pc", pc, 32'd0);

        // halt_req during DECODE of the instruction at pc=5.
        do_reset;
        do_start;
        for (int k = 0; k < 5; k++)
            do_instr(1'b0, 1'b0, 32'h0, 0, 0, 1'b0, 32'(k), 32'(k + 1), 32'(k + 1), 1'b0);
        do_instr(1'b0, 1'b0, 32'h0, 0, 1, 1'b1, 32'd5, 32'd6, 32'd6, 1'b1);
        start = 1'b1;
        tick;
        tick;
        start = 1'b0;
        chk("halt_sticky", 32'(halted), 32'd1);
        chk("halt_no_fetch", 32'(imem_req), 32'd0);
        chk("halt_pc", pc, 32'd6);
        chk("halt_retired", retired, 32'd6);

        // halt_req beats start in IDLE.
        do_reset;
        halt_req = 1'b1;
        start = 1'b1;
        tick;
        halt_req = 1'b0;
        start = 1'b0;
        chk("idle_halt", 32'(halted), 32'd1);
        chk("idle_halt_req", 32'(imem_req), 32'd0);

        // Asynchronous reset in the middle of EXEC at pc=7.
        do_reset;
        do_start;
        for (int k = 0; k < 7; k++)
            do_instr(1'b0, 1'b0, 32'h0, 0, 0, 1'b0, 32'(k), 32'(k + 1), 32'(k + 1), 1'b0);
        imem_valid = 1'b1;
        tick;
        imem_valid = 1'b0;
        tick;
        chk("mid_exec_en", 32'(exec_en), 32'd1);
        chk("mid_exec_ret", retired, 32'd7);
        exec_done = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst_exec_en", 32'(exec_en), 32'd0);
        chk("arst_pc", pc, 32'd0);
        chk("arst_retired", retired, 32'd0);
        chk("arst_halted", 32'(halted), 32'd0);
        chk("arst_req", 32'(imem_req), 32'd0);
        tick;
        rst = 1'b0;
        exec_done = 1'b0;
        tick;
        chk("arst_idle_req", 32'(imem_req), 32'd0);
        chk("arst_idle_pc", pc, 32'd0);
        chk("arst_idle_ret", retired, 32'd0);

        // Randomized instruction stream against an instruction-level model.
        do_reset;
        do_start;
        cur = '0;
        ret = 0;
        for (int n = 0; n < 150; n++) begin
            br  = 1'($urandom_range(0, 1));
            tk  = 1'($urandom_range(0, 1));
            tgt = $urandom;
            nxt = (br && tk) ? tgt : cur + 32'd1;
            ret++;
            do_instr(br, tk, tgt, $urandom_range(0, 6), $urandom_range(0, 4), 1'b0,
                     cur, nxt, 32'(ret), 1'b0);
            cur = nxt;
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL sim_timeout: got %0d checks, required completion", n_tot);
        $fatal(1, "time limit reached");
    end

endmodule
